i2c_target_receiver: RTL and testbench

- I2C target (slave) write receiver; the bus-side counterpart of the team's I2C master transmitter.
- Watches an open-drain SCL/SDA pair, detects START, repeated START and STOP, and matches a 7-bit target address.
- Accepts write-direction bytes MSB first, ACKs each one by pulling SDA low, and presents each received byte on a one-cycle valid strobe.
- Sits on the peripheral side of the bus, feeding a local register file or FIFO.

---
 rtl/i2c_target_receiver.sv | 158 +++++++++++++++
 tb/tb_i2c_target_receiver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/i2c_target_receiver.sv
// rtl/i2c_target_receiver.sv - I2C target write receiver with address match and per-byte ACK
module i2c_target_receiver #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  inout  wire        io_sda,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_busy,
  output logic       o_start_det,
  output logic       o_stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, NACK, IGNORE
  } state_t;

  state_t     state, state_n;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [7:0] shift, shift_n, shift_in;
  logic [2:0] cnt, cnt_n;
  logic       sda_oe, sda_oe_n;
  logic       ack_ph, ack_ph_n;
  logic       busy_n, valid_n, start_n, stop_n;
  logic [7:0] data_n;
  logic       scl_rise, scl_fall, start_ev, stop_ev;

  assign io_sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      scl_s1 <= i_scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= io_sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start_ev = scl_s2 & sda_d & ~sda_s2;
  assign stop_ev  = scl_s2 & ~sda_d & sda_s2;
  assign shift_in = {shift[6:0], sda_s2};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      shift        <= 8'h00;
      cnt          <= 3'd0;
      sda_oe       <= 1'b0;
      ack_ph       <= 1'b0;
      o_busy       <= 1'b0;
      o_data       <= 8'h00;
      o_data_valid <= 1'b0;
      o_start_det  <= 1'b0;
      o_stop_det   <= 1'b0;
    end else begin
      state        <= state_n;
      shift        <= shift_n;
      cnt          <= cnt_n;
      sda_oe       <= sda_oe_n;
      ack_ph       <= ack_ph_n;
      o_busy       <= busy_n;
      o_data       <= data_n;
      o_data_valid <= valid_n;
      o_start_det  <= start_n;
      o_stop_det   <= stop_n;
    end
  end

  always_comb begin
    state_n  = state;
    shift_n  = shift;
    cnt_n    = cnt;
    sda_oe_n = sda_oe;
    ack_ph_n = ack_ph;
    busy_n   = o_busy;
    data_n   = o_data;
    valid_n  = 1'b0;
    start_n  = 1'b0;
    stop_n   = 1'b0;
    // Bus conditions override whatever byte phase is in progress
    if (stop_ev) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      ack_ph_n = 1'b0;
      busy_n   = 1'b0;
      stop_n   = 1'b1;
    end else if (start_ev) begin
      state_n  = ADDR;
      shift_n  = 8'h00;
      cnt_n    = 3'd0;
      sda_oe_n = 1'b0;
      ack_ph_n = 1'b0;
      busy_n   = 1'b0;
      start_n  = 1'b1;
    end else begin
      case (state)
        IDLE, IGNORE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_n = shift_in;
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7)
              state_n = (shift_in[7:1] == TARGET_ADDR && !shift_in[0]) ? ADDR_ACK : IGNORE;
          end
        end
        // First fall pulls SDA low for the 9th clock, second fall releases it
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
              ack_ph_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              ack_ph_n = 1'b0;
              state_n  = DATA;
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_n = shift_in;
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (i_ready) begin
                data_n  = shift_in;
                valid_n = 1'b1;
                state_n = DATA_ACK;
              end else begin
                busy_n  = 1'b0;
                state_n = NACK;
              end
            end
          end
        end
        NACK: begin
          if (scl_fall) begin
            ack_ph_n = ~ack_ph;
            if (ack_ph) state_n = IGNORE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_receiver.sv
// tb/tb_i2c_target_receiver.sv - scoreboard bench for i2c_target_receiver
module tb_i2c_target_receiver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       ready = 1'b1;
  wire        sda;
  logic [7:0] data;
  logic       valid, busy, start_det, stop_det;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target_receiver #(.TARGET_ADDR(7'h42)) dut (
    .i_clk(clk), .i_rst(rst), .i_scl(scl), .io_sda(sda), .i_ready(ready),
    .o_data(data), .o_data_valid(valid), .o_busy(busy),
    .o_start_det(start_det), .o_stop_det(stop_det)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_stop = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (exp_q.size() == 0) check("unexpected valid", {24'h0, data}, 32'hFFFF_FFFF);
        else check("data", {24'h0, data}, {24'h0, exp_q.pop_front()});
      end
      if (start_det) n_start++;
      if (stop_det) n_stop++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    tick(5); m_low = !b; tick(4); scl = 1'b1; tick(8); scl = 1'b0;
  endtask

  task automatic ack_bit(input string name, input logic exp_ack, input logic exp_busy);
    tick(5); m_low = 1'b0; tick(4); scl = 1'b1; tick(4);
    check({name, " ack"}, {31'h0, sda === 1'b0}, {31'h0, exp_ack});
    check({name, " busy"}, {31'h0, busy}, {31'h0, exp_busy});
    tick(4); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input string name, input logic exp_ack, input logic exp_busy);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(name, exp_ack, exp_busy);
  endtask

  task automatic start_c();
    tick(4); m_low = 1'b1; tick(6); scl = 1'b0;
  endtask

  task automatic rstart_c();
    tick(5); m_low = 1'b0; tick(4); scl = 1'b1; tick(6); m_low = 1'b1; tick(6); scl = 1'b0;
  endtask

  task automatic stop_c();
    tick(5); m_low = 1'b1; tick(4); scl = 1'b1; tick(6); m_low = 1'b0; tick(8);
  endtask

  int s0, p0;

  initial begin
    tick(3);
    check("reset data", {24'h0, data}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset valid", {31'h0, valid}, 32'h0);
    check("reset sda", {31'h0, sda}, 32'h1);
    rst = 1'b0;
    tick(4);

    // Basic write: one ACKed data byte
    s0 = n_start; p0 = n_stop;
    exp_q.push_back(8'hA5);
    start_c();
    send_byte(8'h84, "s1 addr", 1'b1, 1'b1);
    send_byte(8'hA5, "s1 data", 1'b1, 1'b1);
    stop_c();
    check("s1 busy after stop", {31'h0, busy}, 32'h0);
    check("s1 start count", n_start - s0, 1);
    check("s1 stop count", n_stop - p0, 1);
    check("s1 o_data", {24'h0, data}, 32'hA5);

    // Other address: fully ignored
    start_c();
    send_byte(8'h86, "s2 addr", 1'b0, 1'b0);
    send_byte(8'h3C, "s2 data", 1'b0, 1'b0);
    stop_c();
    check("s2 o_data", {24'h0, data}, 32'hA5);

    // Matching address with read bit: NACK then ignore
    start_c();
    send_byte(8'h85, "s3 addr", 1'b0, 1'b0);
    send_byte(8'hFF, "s3 data", 1'b0, 1'b0);
    stop_c();

    // Second byte refused by sink
    exp_q.push_back(8'h11);
    start_c();
    send_byte(8'h84, "s4 addr", 1'b1, 1'b1);
    send_byte(8'h11, "s4 d1", 1'b1, 1'b1);
    ready = 1'b0;
    send_byte(8'h22, "s4 d2", 1'b0, 1'b0);
    ready = 1'b1;
    check("s4 o_data", {24'h0, data}, 32'h11);
    check("s4 busy", {31'h0, busy}, 32'h0);
    stop_c();

    // Repeated START mid-byte
    s0 = n_start;
    exp_q.push_back(8'h5A);
    start_c();
    send_byte(8'h84, "s5 addr1", 1'b1, 1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rstart_c();
    send_byte(8'h84, "s5 addr2", 1'b1, 1'b1);
    send_byte(8'h5A, "s5 data", 1'b1, 1'b1);
    stop_c();
    check("s5 start count", n_start - s0, 2);
    check("s5 o_data", {24'h0, data}, 32'h5A);

    // Reset while ACK is being driven
    start_c();
    for (int i = 7; i >= 0; i--) send_bit(((8'h84 >> i) & 8'h1) != 8'h0);
    tick(5); m_low = 1'b0; tick(4); scl = 1'b1; tick(4);
    check("s6 ack before reset", {31'h0, sda === 1'b0}, 32'h1);
    #3 rst = 1'b1;
    #1;
    check("s6 sda released", {31'h0, sda}, 32'h1);
    check("s6 busy", {31'h0, busy}, 32'h0);
    check("s6 o_data", {24'h0, data}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(4);
    exp_q.push_back(8'h77);
    start_c();
    send_byte(8'h84, "s6 addr", 1'b1, 1'b1);
    send_byte(8'h77, "s6 data", 1'b1, 1'b1);
    stop_c();
    check("s6 o_data after", {24'h0, data}, 32'h77);

    tick(4);
    check("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
